// File: rtl/victim_cache_ctrl.sv
// 8-entry fully associative victim cache: accepts L1 evictions, answers L1-miss
// lookups, drives the external LRU tracker and writes back displaced dirty blocks.
module victim_cache_ctrl #(
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 128,
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_ready,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [DATA_W-1:0]  resp_data,
  input  logic               evict_valid,
  input  logic [TAG_W-1:0]   evict_tag,
  input  logic [DATA_W-1:0]  evict_data,
  input  logic               evict_dirty,
  output logic               evict_ready,
  input  logic [ENTRIES-1:0] lru_number,
  output logic [ENTRIES-1:0] lru_update,
  output logic               add_cache,
  output logic               wb_valid,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [DATA_W-1:0]  wb_data,
  input  logic               wb_ready,
  output logic [3:0]         occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, INSERT, WRITEBACK} state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid, dirty;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [DATA_W-1:0]  data_mem [ENTRIES];

  logic [TAG_W-1:0]   req_tag;
  logic [DATA_W-1:0]  req_data;
  logic               req_dirty;
  logic [TAG_W-1:0]   wb_tag_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic [3:0]         occ;

  logic [ENTRIES-1:0] match_vec;
  logic               hit, any_free, need_wb;
  logic [IDX_W-1:0]   hit_idx, free_idx, lru_idx, ins_idx;

  // Lowest set bit wins; an all-zero vector maps to entry 0.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
    lowest_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  function automatic logic [ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(ENTRIES-1){1'b0}}, 1'b1} << idx;
  endfunction

  // The registered tag serves both the lookup compare and the insert match.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      match_vec[i] = valid[i] && (tag_mem[i] == req_tag);
  end

  assign hit      = |match_vec;
  assign hit_idx  = lowest_idx(match_vec);
  assign any_free = |(~valid);
  assign free_idx = lowest_idx(~valid);
  assign lru_idx  = lowest_idx(lru_number);
  assign ins_idx  = hit ? hit_idx : (any_free ? free_idx : lru_idx);
  assign need_wb  = !hit && !any_free && valid[ins_idx] && dirty[ins_idx];

  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_data  = '0;
    lru_update = '0;
    add_cache  = 1'b0;
    wb_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_valid)     state_nxt = LOOKUP;
        else if (evict_valid) state_nxt = INSERT;
      end
      LOOKUP: begin
        resp_valid = 1'b1;
        resp_hit   = hit;
        if (hit) begin
          resp_data  = data_mem[hit_idx];
          lru_update = onehot(hit_idx);
        end
        state_nxt = IDLE;
      end
      INSERT: begin
        if (hit || any_free || (lru_number == '0)) lru_update = onehot(ins_idx);
        else                                       add_cache  = 1'b1;
        state_nxt = need_wb ? WRITEBACK : IDLE;
      end
      WRITEBACK: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lookup_ready = (state == IDLE);
  assign evict_ready  = (state == IDLE);
  assign wb_tag       = wb_valid ? wb_tag_r  : '0;
  assign wb_data      = wb_valid ? wb_data_r : '0;
  assign occupancy    = occ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      occ   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INSERT) begin
        valid[ins_idx] <= 1'b1;
        dirty[ins_idx] <= hit ? (dirty[ins_idx] | req_dirty) : req_dirty;
        if (!hit && any_free) occ <= occ + 4'd1;
      end
    end
  end

  // Payload storage: captured on handshakes, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (lookup_valid) begin
        req_tag <= lookup_tag;
      end else if (evict_valid) begin
        req_tag   <= evict_tag;
        req_data  <= evict_data;
        req_dirty <= evict_dirty;
      end
    end
    if (state == INSERT) begin
      wb_tag_r          <= tag_mem[ins_idx];
      wb_data_r         <= data_mem[ins_idx];
      tag_mem[ins_idx]  <= req_tag;
      data_mem[ins_idx] <= req_data;
    end
  end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Control and storage for the 8-entry fully associative victim cache.
- Accepts blocks evicted from L1 and services L1-miss lookups.
- Writes back dirty victims it displaces.
- Sits directly upstream of the 8-way LRU tracker: consumes its one-hot lru_number and drives its lru_update/add_cache pulses.

Parameters:
- TAG_W, 26, block tag width.
- DATA_W, 128, block data width.
- ENTRIES, 8, entry count; fixed at 8 to match the LRU tracker.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  L1 miss request.
- lookup_tag  in  TAG_W  requested tag.
- lookup_ready  out  1  request accepted when valid&ready.
- resp_valid  out  1  one-cycle lookup response strobe.
- resp_hit  out  1  hit flag, qualified by resp_valid.
- resp_data  out  DATA_W  hit data, qualified by resp_valid&resp_hit.
- evict_valid  in  1  L1 victim insert request.
- evict_tag  in  TAG_W  victim tag.
- evict_data  in  DATA_W  victim data.
- evict_dirty  in  1  victim dirty flag.
- evict_ready  out  1  insert accepted when valid&ready.
- lru_number  in  8  one-hot least-recently-used entry from the LRU tracker.
- lru_update  out  8  one-hot one-cycle pulse marking an entry most recent.
- add_cache  out  1  one-cycle pulse: LRU tracker promotes its current LRU entry.
- wb_valid  out  1  dirty writeback request to memory.
- wb_tag  out  TAG_W  writeback tag.
- wb_data  out  DATA_W  writeback data.
- wb_ready  in  1  memory accepts writeback when valid&ready.
- occupancy  out  4  count of valid entries, 0..8.

Behaviour:
- Per-entry state: valid, dirty, tag, data.
  - Reset clears valid and dirty; tag/data are not reset.
- Reset values of outputs: lookup_ready=1 and evict_ready=1 (IDLE), all other outputs 0.
  - Reset asserted mid-operation returns the FSM to IDLE immediately and drops wb_valid; a pending insert is lost.
- FSM states: IDLE, LOOKUP, INSERT, WRITEBACK.
  - lookup_ready = evict_ready = (state==IDLE).
- Arbitration: if lookup_valid and evict_valid are both high in IDLE, the lookup wins. evict_ready is still high that cycle, but the evict handshake is not taken; the source must hold its request.
- IDLE -> LOOKUP on lookup handshake; tag registered.
- LOOKUP (accept cycle +1):
  - Compare the registered tag against all valid entries.
  - resp_valid=1 for exactly this cycle, with resp_hit and, on hit, resp_data of the matching entry.
  - On hit: lru_update = one-hot of the hit entry this cycle; the entry stays valid.
  - On miss: lru_update=0.
  - Next state IDLE.
- IDLE -> INSERT on evict handshake; tag/data/dirty registered. Target selection in INSERT, in priority order:
  - (a) a valid entry whose tag equals evict_tag: overwrite in place; dirty = old dirty | evict_dirty; pulse lru_update for that entry.
  - (b) else the lowest-index invalid entry: pulse lru_update for it; occupancy += 1.
  - (c) else the entry given by lru_number; pulse add_cache, with lru_update=0.
    - If lru_number is not one-hot, use its lowest set bit.
    - If lru_number==0, use entry 0 and pulse lru_update[0] instead of add_cache.
- Write timing:
  - In cases (a), (b), and (c) with a clean displaced entry: entry written at the INSERT edge, next state IDLE; total latency 1 cycle after handshake.
  - In case (c) with a valid dirty displaced entry: the LRU pulse fires in INSERT and the victim is written at the INSERT edge. The old tag/data are first captured into the writeback register, and the FSM moves to WRITEBACK.
- WRITEBACK:
  - wb_valid=1 with stable wb_tag/wb_data until wb_ready.
  - On handshake, wb_valid drops the next cycle and the FSM returns to IDLE.
  - No lookups or inserts are accepted in this state.
- occupancy never exceeds 8, is never decremented except by reset, and equals popcount(valid).
- lru_update and add_cache are never both nonzero in the same cycle. Each is high for at most one cycle per operation.

Test Plan:
- Reset, then 8 inserts, tags 0x10..0x17, clean -> entries 0..7 filled in order; lru_update pulses 0x01,0x02,..0x80; occupancy 8; add_cache never asserts.
- Lookup 0x13 after fill -> resp_valid one cycle after handshake, resp_hit=1, resp_data=entry 3 data, lru_update=0x08. Lookup 0x99 -> resp_hit=0, lru_update=0x00.
- Full cache, lru_number=0x20, insert tag 0x20 dirty, then insert tag 0x21 with lru_number=0x20:
  - First insert: add_cache pulses once, entry 5 gets tag 0x20, no writeback.
  - Second insert: wb_valid with wb_tag=0x20, held while wb_ready=0 for 3 cycles; ready stays 0 until the wb handshake.
- Insert tag 0x12 while 0x12 is resident -> in-place overwrite of entry 2, occupancy unchanged, lru_update=0x04.
- Simultaneous lookup_valid and evict_valid in IDLE -> lookup handled first; evict accepted on the next IDLE cycle.
- Assert reset during WRITEBACK -> wb_valid=0 and ready=1 immediately; occupancy 0; a subsequent lookup of any prior tag misses.
